tick_period_monitor: RTL and testbench
======================================

# tick_period_monitor

Receive-side checker for the one-cycle tick pulses produced by the game-speed rate dividers. It measures the number of `clkin` cycles between consecutive ticks and compares each measurement against a programmable expected period and tolerance. It reports lock once the tick stream has been stable for several periods, and flags a timeout when ticks stop. It sits between the selected rate divider and the game logic, and lets the speed-select path be checked in hardware.

## Interface
- `CW`, 22: width of the period counter, `expected`, and `period`.
- `TIMEOUT_CYCLES`, 4000000: cycles without an edge before timeout. Must be ≥2 and ≤ 2^CW−1.
- `LOCK_COUNT`, 3: number of consecutive in-range periods required to assert `locked`. Range 1..15.
- `clkin` input 1: sole clock, rising edge.
- `resetn` input 1: reset, asynchronous, active-low.
- `tick_in` input 1: tick pulse, synchronous to `clkin`. Normally high for one cycle.
- `expected` input CW: nominal period in cycles. A rate divider with terminal count N gives period N+1.
- `tol` input 8: allowed absolute deviation in cycles, zero-extended.
- `period` output CW: last measured period.
- `period_valid` output 1: one-cycle strobe, high when `period`/`in_range` update.
- `in_range` output 1: result of the last comparison.
- `locked` output 1: `LOCK_COUNT` consecutive in-range periods seen.
- `timeout` output 1: level; no edge for `TIMEOUT_CYCLES` cycles.

## Operation
- **Edge detection:**
  - `edge = tick_in & ~tick_q`, where `tick_q` is `tick_in` registered.
  - A multi-cycle-high tick counts as one edge.
  - No synchronizer; `tick_in` is same-domain.
- **FSM states:** IDLE and MEASURE. Reset enters IDLE.
- **In IDLE:**
  - `cnt` holds 0.
  - On `edge`: go to MEASURE, `cnt <= 1`, clear `timeout`. No `period_valid`.
- **In MEASURE, on `edge`:**
  - `period <= cnt` (equals t1−t0 in cycles).
  - `cnt <= 1`.
  - `period_valid <= 1`.
  - `in_range <= (|cnt − expected| <= tol)`, computed in CW+1 bits signed.
  - `expected` and `tol` are sampled only on that cycle.
- **In MEASURE, no `edge`:**
  - `cnt <= cnt + 1`.
  - When `cnt == TIMEOUT_CYCLES`: `timeout <= 1`, go to IDLE, clear `lock_cnt`.
  - `period` and `in_range` retain their values.
- **Lock counter (4 bits), on each `period_valid`:**
  - If in range: increment, saturating at `LOCK_COUNT`.
  - Otherwise: clear to 0.
  - `locked = (lock_cnt == LOCK_COUNT)`, registered.
- **Priority:** `edge` beats timeout in the same cycle; the edge is measured normally and no timeout occurs.
- **Counter range:** `cnt` never exceeds `TIMEOUT_CYCLES`, so no wrap.

## Timing
- **Reset values:** all outputs 0; `cnt`=0, `lock_cnt`=0, `tick_q`=0, state IDLE.
- **Asynchronous reset:** `resetn` low clears everything immediately, mid-measurement included. The first edge after release is treated as the IDLE edge.
- **Update latency:** `period`, `period_valid`, and `in_range` are registered on the posedge that samples `edge`. They are visible in the following cycle.
- **`period_valid`:** high for exactly one cycle per measured edge.
- **`locked` latency:** updates on the same posedge as `period_valid`, so it rises together with the `LOCK_COUNT`-th in-range strobe. It falls with the first out-of-range strobe or with timeout.
- **`timeout` timing:** asserts on the posedge where `cnt == TIMEOUT_CYCLES` with no edge, i.e. `TIMEOUT_CYCLES` cycles after the last edge. It stays high until the next edge, and clears on that edge's posedge.
- **Minimum period:** 2 cycles, since `tick_in` must be low between edges. Back-to-back edges 2 cycles apart yield `period` = 2.

## Test plan
- **Reset:** assert `resetn`=0 mid-run with `cnt` ≈ 7 → all outputs 0 immediately. After release, the first tick gives no `period_valid`.
- **Lock on nominal rate:** `expected`=10, `tol`=0, ticks every 10 cycles →
  - no strobe on the 1st tick;
  - on the 2nd tick, `period`=10, `in_range`=1;
  - `locked`=1 together with the 3rd strobe (4th tick) when `LOCK_COUNT`=3.
- **Out of range:** from locked, one interval of 12 with `expected`=10, `tol`=1 → `in_range`=0, `locked`=0. Retry with `tol`=2 on a 12-cycle interval → `in_range`=1.
- **Timeout:** bench with `TIMEOUT_CYCLES`=50; stop ticks →
  - `timeout`=1 exactly 50 cycles after the last edge; `locked`=0;
  - next tick clears `timeout` with no strobe;
  - the following tick 10 cycles later gives `period`=10.
- **Wide pulse and edge-beats-timeout:**
  - Hold `tick_in` high for 5 cycles, repeating every 20 cycles → `period`=20, one strobe per pulse.
  - An edge landing on cycle `cnt==TIMEOUT_CYCLES` → `period`=50, `timeout` stays 0.

Source files
------------

// File: rtl/tick_period_monitor.sv
// rtl/tick_period_monitor.sv - measures tick-to-tick period, checks tolerance, reports lock and timeout
// Two-state measurement FSM; all outputs are registered on the edge-sampling posedge.
module tick_period_monitor #(
  parameter int CW             = 22,
  parameter int TIMEOUT_CYCLES = 4000000,
  parameter int LOCK_COUNT     = 3
) (
  input  logic          clkin,
  input  logic          resetn,
  input  logic          tick_in,
  input  logic [CW-1:0] expected,
  input  logic [7:0]    tol,
  output logic [CW-1:0] period,
  output logic          period_valid,
  output logic          in_range,
  output logic          locked,
  output logic          timeout
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LIMIT  = CW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    LOCK_LIMIT = 4'(LOCK_COUNT);
  localparam logic [CW:0]   DIFF_ONE   = {{CW{1'b0}}, 1'b1};

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_tick_q;
  logic [3:0]      r_lock_cnt;

  logic            w_edge;
  logic signed [CW:0] w_diff;
  logic [CW:0]     w_abs;
  logic [CW:0]     w_tol_ext;
  logic            w_in_range;
  logic [3:0]      w_lock_next;

  assign w_edge = tick_in & ~r_tick_q;

  // Deviation is taken in CW+1 signed bits so a count below expected stays representable.
  assign w_diff      = $signed({1'b0, r_cnt}) - $signed({1'b0, expected});
  assign w_abs       = w_diff[CW] ? (~w_diff + DIFF_ONE) : w_diff;
  assign w_tol_ext   = {{(CW-7){1'b0}}, tol};
  assign w_in_range  = (w_abs <= w_tol_ext);
  assign w_lock_next = !w_in_range               ? 4'd0 :
                       (r_lock_cnt == LOCK_LIMIT) ? LOCK_LIMIT :
                                                    r_lock_cnt + 4'd1;

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_tick_q     <= 1'b0;
      r_lock_cnt   <= 4'd0;
      period       <= '0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      r_tick_q     <= tick_in;
      period_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_edge) begin
            r_state <= S_MEASURE;
            r_cnt   <= CNT_ONE;
            timeout <= 1'b0;
          end
        end
        S_MEASURE: begin
          // An edge always wins over an expiring count on the same cycle.
          if (w_edge) begin
            period       <= r_cnt;
            r_cnt        <= CNT_ONE;
            period_valid <= 1'b1;
            in_range     <= w_in_range;
            r_lock_cnt   <= w_lock_next;
            locked       <= (w_lock_next == LOCK_LIMIT);
          end else if (r_cnt == CNT_LIMIT) begin
            timeout    <= 1'b1;
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lock_cnt <= 4'd0;
            locked     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_period_monitor.sv
// tb/tb_tick_period_monitor.sv - randomized bench for tick_period_monitor against a timestamp model
// The model records edge timestamps and derives period, range, lock and timeout arithmetically.
module tb_tick_period_monitor;

  localparam int CW   = 22;
  localparam int TO   = 50;
  localparam int LOCK = 3;

  logic          clkin;
  logic          resetn;
  logic          tick_in;
  logic [CW-1:0] expected;
  logic [7:0]    tol;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          in_range;
  logic          locked;
  logic          timeout;

  tick_period_monitor #(.CW(CW), .TIMEOUT_CYCLES(TO), .LOCK_COUNT(LOCK)) dut (
    .clkin(clkin), .resetn(resetn), .tick_in(tick_in), .expected(expected), .tol(tol),
    .period(period), .period_valid(period_valid), .in_range(in_range),
    .locked(locked), .timeout(timeout)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_fail   = 0;

  int cur_exp = 10;
  int cur_tol = 0;

  int m_now, m_last, m_run, m_period;
  bit m_meas, m_prev, m_pv, m_inr, m_locked, m_to;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_now = 0; m_last = 0; m_run = 0; m_period = 0;
    m_meas = 0; m_prev = 0; m_pv = 0; m_inr = 0; m_locked = 0; m_to = 0;
  endtask

  // One posedge of behaviour given the inputs presented to it.
  task automatic model_step(input bit t);
    bit e;
    int dev;
    e = t && !m_prev;
    m_prev = t;
    m_pv = 0;
    if (e) begin
      if (m_meas) begin
        m_period = m_now - m_last;
        m_pv = 1;
        dev = m_period - cur_exp;
        if (dev < 0) dev = -dev;
        m_inr = (dev <= cur_tol);
        m_run = m_inr ? m_run + 1 : 0;
        m_locked = (m_run >= LOCK);
      end
      m_meas = 1;
      m_last = m_now;
      m_to = 0;
    end else if (m_meas && (m_now - m_last == TO)) begin
      m_to = 1;
      m_meas = 0;
      m_run = 0;
      m_locked = 0;
    end
    m_now++;
  endtask

  task automatic compare_all();
    check_eq("period", 32'(period), 32'(m_period));
    check_eq("period_valid", 32'(period_valid), 32'(m_pv));
    check_eq("in_range", 32'(in_range), 32'(m_inr));
    check_eq("locked", 32'(locked), 32'(m_locked));
    check_eq("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic tick_cycle(input bit t);
    @(negedge clkin);
    compare_all();
    tick_in  = t;
    expected = CW'(cur_exp);
    tol      = 8'(cur_tol);
    model_step(t);
  endtask

  task automatic pulse(input int p, input int w, input bit jitter);
    for (int i = 0; i < p; i++) begin
      if (jitter && ($urandom_range(0, 7) == 0))
        cur_exp = (cur_exp > 2) ? cur_exp + $urandom_range(0, 2) - 1 : cur_exp + 1;
      tick_cycle(i < w);
    end
  endtask

  initial begin
    resetn = 1'b0; tick_in = 1'b0; expected = '0; tol = '0;
    model_reset();
    #23;
    compare_all();
    @(negedge clkin);
    resetn = 1'b1;

    // Lock at nominal rate
    cur_exp = 10; cur_tol = 0;
    for (int k = 0; k < 5; k++) pulse(10, 1, 0);
    check_eq("nominal_period", 32'(period), 32'd10);
    check_eq("nominal_locked", 32'(locked), 32'd1);

    // Out of range, then accepted with wider tolerance
    cur_tol = 1;
    pulse(12, 1, 0); pulse(10, 1, 0);
    check_eq("oor_period", 32'(period), 32'd12);
    check_eq("oor_in_range", 32'(in_range), 32'd0);
    check_eq("oor_locked", 32'(locked), 32'd0);
    cur_tol = 2;
    pulse(12, 1, 0); pulse(10, 1, 0);
    check_eq("tol2_in_range", 32'(in_range), 32'd1);

    // Timeout and recovery
    for (int k = 0; k < 55; k++) tick_cycle(0);
    check_eq("to_timeout", 32'(timeout), 32'd1);
    check_eq("to_locked", 32'(locked), 32'd0);
    cur_tol = 0;
    pulse(10, 1, 0); pulse(10, 1, 0);
    check_eq("rec_timeout", 32'(timeout), 32'd0);
    check_eq("rec_period", 32'(period), 32'd10);

    // Wide pulses
    cur_exp = 20;
    for (int k = 0; k < 4; k++) pulse(20, 5, 0);
    check_eq("wide_period", 32'(period), 32'd20);

    // Edge on the expiring cycle, then one cycle too late
    cur_exp = 50;
    for (int k = 0; k < 3; k++) pulse(50, 1, 0);
    check_eq("etb_period", 32'(period), 32'd50);
    check_eq("etb_timeout", 32'(timeout), 32'd0);
    pulse(51, 1, 0); pulse(10, 1, 0);
    check_eq("late_period", 32'(period), 32'd50);

    // Asynchronous reset mid-measurement
    cur_exp = 10;
    for (int k = 0; k < 3; k++) pulse(10, 1, 0);
    for (int k = 0; k < 6; k++) tick_cycle(0);
    #2 resetn = 1'b0;
    #1;
    check_eq("arst_period", 32'(period), 32'd0);
    check_eq("arst_locked", 32'(locked), 32'd0);
    check_eq("arst_in_range", 32'(in_range), 32'd0);
    model_reset();
    @(negedge clkin);
    compare_all();
    resetn = 1'b1;
    pulse(10, 1, 0); pulse(10, 1, 0);

    // Randomized streams with jittering expected value
    for (int k = 0; k < 150; k++) begin
      int p, w;
      p = (k % 40 == 39) ? TO + $urandom_range(0, 3) : $urandom_range(2, 30);
      w = $urandom_range(1, p - 1);
      cur_exp = p + $urandom_range(0, 6) - 3;
      if (cur_exp < 1) cur_exp = 1;
      cur_tol = $urandom_range(0, 3);
      pulse(p, w, ($urandom_range(0, 3) == 0));
    end
    tick_cycle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
